// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with valid/ready handshake and flush.
// Define PIPE_STAGE_SKID_EN for a two-entry stage with a fully registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    localparam beat_t EMPTY_BEAT = '0;

    beat_t inBeat;
    beat_t mainQ;
    beat_t mainD;
    logic  mainValidQ;
    logic  mainValidD;
    logic  inFire;
    logic  outFire;

    assign inBeat    = {in_ctrl, in_data};
    assign outFire   = mainValidQ & out_ready;
    assign out_valid = mainValidQ;
    assign out_ctrl  = mainQ.ctrl;
    assign out_data  = mainQ.data;

`ifdef PIPE_STAGE_SKID_EN
    beat_t      skidQ;
    beat_t      skidD;
    logic       skidValidQ;
    logic       skidValidD;
    logic       inReadyQ;
    logic       inReadyD;
    logic [1:0] occQ;
    logic [1:0] occD;

    assign inFire    = in_valid & inReadyQ;
    assign in_ready  = inReadyQ;
    assign occupancy = occQ;

    // Main entry feeds the output; the skid entry catches a beat arriving during a stall.
    always_comb begin
        mainD      = mainQ;
        mainValidD = mainValidQ;
        skidD      = skidQ;
        skidValidD = skidValidQ;
        if (flush) begin
            mainD      = EMPTY_BEAT;
            mainValidD = 1'b0;
            skidD      = EMPTY_BEAT;
            skidValidD = 1'b0;
        end else if (outFire) begin
            if (skidValidQ) begin
                mainD      = skidQ;
                mainValidD = 1'b1;
                skidD      = inFire ? inBeat : EMPTY_BEAT;
                skidValidD = inFire;
            end else begin
                mainD      = inFire ? inBeat : EMPTY_BEAT;
                mainValidD = inFire;
            end
        end else if (inFire) begin
            if (!mainValidQ) begin
                mainD      = inBeat;
                mainValidD = 1'b1;
            end else begin
                skidD      = inBeat;
                skidValidD = 1'b1;
            end
        end
        occD     = 2'(mainValidD) + 2'(skidValidD);
        inReadyD = (occD != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skidQ      <= EMPTY_BEAT;
            skidValidQ <= 1'b0;
            inReadyQ   <= 1'b1;
            occQ       <= 2'd0;
        end else begin
            skidQ      <= skidD;
            skidValidQ <= skidValidD;
            inReadyQ   <= inReadyD;
            occQ       <= occD;
        end
    end
`else
    assign in_ready  = out_ready | ~mainValidQ;
    assign inFire    = in_valid & in_ready;
    assign occupancy = {1'b0, mainValidQ};

    // Single entry: load on accept, zero on drain so idle outputs read 0.
    always_comb begin
        mainD      = mainQ;
        mainValidD = mainValidQ;
        if (flush) begin
            mainD      = EMPTY_BEAT;
            mainValidD = 1'b0;
        end else if (inFire) begin
            mainD      = inBeat;
            mainValidD = 1'b1;
        end else if (outFire) begin
            mainD      = EMPTY_BEAT;
            mainValidD = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainQ      <= EMPTY_BEAT;
            mainValidQ <= 1'b0;
        end else begin
            mainQ      <= mainD;
            mainValidQ <= mainValidD;
        end
    end

endmodule
